ram8_scan: RTL

//   8-word x 16-bit register memory (Hack RAM8 semantics) whose read path is built

---
 rtl/ram8_scan.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ram8_scan.sv
// 8x16 Hack-style RAM8 with a combinational read port and a
// valid/ready scan engine that streams words 0..7 in order.

module mux8way16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_e,
    input  logic [WIDTH-1:0] i_f,
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_h,
    input  logic [2:0]       i_sel,
    output logic [WIDTH-1:0] o_out
);
    always_comb begin
        o_out = i_a;
        case (i_sel)
            3'd0: o_out = i_a;
            3'd1: o_out = i_b;
            3'd2: o_out = i_c;
            3'd3: o_out = i_d;
            3'd4: o_out = i_e;
            3'd5: o_out = i_f;
            3'd6: o_out = i_g;
            3'd7: o_out = i_h;
        endcase
    end
endmodule

module ram8_scan #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    output logic [WIDTH-1:0] out,
    input  logic             scan_start,
    output logic             scan_busy,
    output logic             scan_valid,
    input  logic             scan_ready,
    output logic [WIDTH-1:0] scan_data,
    output logic [2:0]       scan_addr,
    output logic             scan_done
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    logic [WIDTH-1:0] r_ram [8];

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic [2:0]       r_addr;
    logic [2:0]       w_addr_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [2:0]       w_rd_sel;
    logic [WIDTH-1:0] w_scan_word;
    logic             w_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_ram[i] <= '0;
            end
        end else if (load) begin
            r_ram[address] <= in;
        end
    end

    mux8way16 #(.WIDTH(WIDTH)) u_mux_a (
        .i_a   (r_ram[0]),
        .i_b   (r_ram[1]),
        .i_c   (r_ram[2]),
        .i_d   (r_ram[3]),
        .i_e   (r_ram[4]),
        .i_f   (r_ram[5]),
        .i_g   (r_ram[6]),
        .i_h   (r_ram[7]),
        .i_sel (address),
        .o_out (out)
    );

    // Scan read looks one word ahead so the capture lands with the pointer.
    assign w_rd_sel = (r_state == S_IDLE) ? 3'd0 : r_addr + 3'd1;

    mux8way16 #(.WIDTH(WIDTH)) u_mux_b (
        .i_a   (r_ram[0]),
        .i_b   (r_ram[1]),
        .i_c   (r_ram[2]),
        .i_d   (r_ram[3]),
        .i_e   (r_ram[4]),
        .i_f   (r_ram[5]),
        .i_g   (r_ram[6]),
        .i_h   (r_ram[7]),
        .i_sel (w_rd_sel),
        .o_out (w_scan_word)
    );

    assign w_xfer = r_valid & scan_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                if (scan_start) begin
                    w_state_nxt = S_STREAM;
                    w_valid_nxt = 1'b1;
                    w_addr_nxt  = 3'd0;
                    w_data_nxt  = w_scan_word;
                end
            end
            S_STREAM: begin
                if (w_xfer) begin
                    if (r_addr == 3'd7) begin
                        w_state_nxt = S_DONE;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_addr_nxt = r_addr + 3'd1;
                        w_data_nxt = w_scan_word;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign scan_busy  = (r_state != S_IDLE);
    assign scan_done  = (r_state == S_DONE);
    assign scan_valid = r_valid;
    assign scan_data  = r_data;
    assign scan_addr  = r_addr;

endmodule
